// File: rtl/multiport_register_file.sv
// Multi-port general-purpose register file with hardwired zero register,
// optional same-cycle write bypass, highest-port-wins writes and a busy scoreboard.
module multiport_register_file #(
   parameter int WordLen    = 32,
   parameter int WordCount  = 32,
   parameter int ReadPorts  = 2,
   parameter int WritePorts = 2,
   parameter int ZeroReg    = 1,
   parameter int Bypass     = 1,
   localparam int AW        = (WordCount > 1) ? $clog2(WordCount) : 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [WritePorts-1:0]           RegWrite,
   input  logic [WritePorts*AW-1:0]        writeRegister,
   input  logic [WritePorts*WordLen-1:0]   WriteData,
   input  logic [ReadPorts*AW-1:0]         readRegister,
   output logic [ReadPorts*WordLen-1:0]    ReadData,
   output logic [ReadPorts-1:0]            readBusy,
   input  logic                            reserveValid,
   input  logic [AW-1:0]                   reserveRegister,
   output logic [WordCount-1:0]            busyMask
);

   logic [WordLen-1:0]   regs  [WordCount];
   logic [WordLen-1:0]   wrVal [WordCount];
   logic [WordCount-1:0] wrEn;
   logic [WordCount-1:0] resvHit;
   logic [ReadPorts-1:0] rdHit;

   // Register 0 is dead storage when the zero register is enabled.
   function automatic logic isLive(input int idx);
      return !((ZeroReg != 0) && (idx == 0));
   endfunction

   // Per-register write decode. Ports are scanned in ascending order so the
   // highest-index port targeting a register overrides the lower ones. Addresses
   // at or beyond WordCount match no register and simply fall away.
   always_comb begin : writeDecode
      for (int i = 0; i < WordCount; i++) begin
         // NOTE: every always_comb output gets a default before any conditional
         // assignment; a path that leaves it unassigned would infer a latch.
         wrEn[i]    = 1'b0;
         wrVal[i]   = '0;
         resvHit[i] = reserveValid && (reserveRegister == AW'(i)) && isLive(i);
         for (int k = 0; k < WritePorts; k++) begin
            if (RegWrite[k] && (writeRegister[k*AW +: AW] == AW'(i)) && isLive(i)) begin
               wrEn[i]  = 1'b1;
               wrVal[i] = WriteData[k*WordLen +: WordLen];
            end
         end
      end
   end

   // NOTE: the whole array is cleared by reset, so it maps to flops rather than
   // a RAM macro; a RAM-backed variant would have to drop the storage clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments only, so every
         // flop samples the pre-edge values regardless of statement order.
         for (int i = 0; i < WordCount; i++) regs[i] <= '0;
         busyMask <= '0;
      end else begin
         for (int i = 0; i < WordCount; i++) begin
            if (wrEn[i]) regs[i] <= wrVal[i];
            // A same-cycle reserve beats the retiring write: the register stays busy.
            busyMask[i] <= resvHit[i] | (busyMask[i] & ~wrEn[i]);
         end
      end
   end

   // Read mux: stored value first, then the bypass overrides it for live,
   // in-range addresses. readBusy always reflects the registered scoreboard.
   always_comb begin : readMux
      ReadData = '0;
      readBusy = '0;
      rdHit    = '0;
      for (int p = 0; p < ReadPorts; p++) begin
         for (int i = 0; i < WordCount; i++) begin
            if ((readRegister[p*AW +: AW] == AW'(i)) && isLive(i)) begin
               ReadData[p*WordLen +: WordLen] = regs[i];
               readBusy[p]                    = busyMask[i];
               rdHit[p]                       = 1'b1;
            end
         end
         if ((Bypass != 0) && rdHit[p]) begin
            for (int k = 0; k < WritePorts; k++) begin
               if (RegWrite[k] && (writeRegister[k*AW +: AW] == readRegister[p*AW +: AW]))
                  ReadData[p*WordLen +: WordLen] = WriteData[k*WordLen +: WordLen];
            end
         end
      end
   end

endmodule

// File: tb/tb_multiport_register_file.sv
// Self-checking bench: a bypassed and a non-bypassed default-size instance share
// one stimulus table; a 24x16, 4R/3W instance covers the parameter sweep.
module tb_multiport_register_file;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Shared stimulus for the two default-size instances.
   logic [1:0]  we;
   logic [9:0]  wa;
   logic [63:0] wd;
   logic [9:0]  ra;
   logic        rv;
   logic [4:0]  rr;
   logic [63:0] aRd, bRd;
   logic [1:0]  aBusy, bBusy;
   logic [31:0] aMask, bMask;

   // Sweep instance: 24 words of 16 bits, 4 read and 3 write ports.
   logic [2:0]  cWe;
   logic [14:0] cWa;
   logic [47:0] cWd;
   logic [19:0] cRa;
   logic        cRv;
   logic [4:0]  cRr;
   logic [63:0] cRd;
   logic [3:0]  cBusy;
   logic [23:0] cMask;

   int nChecks = 0;
   int nFails  = 0;

   multiport_register_file #(.Bypass(1)) dutA (
      .clk(clk), .rst(rst), .RegWrite(we), .writeRegister(wa), .WriteData(wd),
      .readRegister(ra), .ReadData(aRd), .readBusy(aBusy),
      .reserveValid(rv), .reserveRegister(rr), .busyMask(aMask));

   multiport_register_file #(.Bypass(0)) dutB (
      .clk(clk), .rst(rst), .RegWrite(we), .writeRegister(wa), .WriteData(wd),
      .readRegister(ra), .ReadData(bRd), .readBusy(bBusy),
      .reserveValid(rv), .reserveRegister(rr), .busyMask(bMask));

   multiport_register_file #(.WordLen(16), .WordCount(24), .ReadPorts(4), .WritePorts(3)) dutC (
      .clk(clk), .rst(rst), .RegWrite(cWe), .writeRegister(cWa), .WriteData(cWd),
      .readRegister(cRa), .ReadData(cRd), .readBusy(cBusy),
      .reserveValid(cRv), .reserveRegister(cRr), .busyMask(cMask));

   typedef struct {
      logic [1:0]  we;
      logic [4:0]  wa0;
      logic [31:0] wd0;
      logic [4:0]  wa1;
      logic [31:0] wd1;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic        rv;
      logic [4:0]  rr;
      logic [31:0] expA0;
      logic [31:0] expA1;
      logic [31:0] expB0;
      logic [1:0]  expBusy;
      logic [31:0] expMask;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] sweepData(input int a);
      return 16'(32'h4000 + a * 32'h0101);
   endfunction

   function automatic logic [15:0] sweepExp(input int a);
      return (a == 0) ? 16'h0 : sweepData(a);
   endfunction

   // Drive one table row at the negedge, check the pre-edge outputs, then let
   // the following posedge commit it.
   task automatic applyVec(input vec_t v, input int idx);
      @(negedge clk);
      we = v.we;
      wa = {v.wa1, v.wa0};
      wd = {v.wd1, v.wd0};
      ra = {v.ra1, v.ra0};
      rv = v.rv;
      rr = v.rr;
      #1;
      check($sformatf("v%0d rdA0", idx), aRd[31:0], v.expA0);
      check($sformatf("v%0d rdA1", idx), aRd[63:32], v.expA1);
      check($sformatf("v%0d rdB0", idx), bRd[31:0], v.expB0);
      check($sformatf("v%0d busyA", idx), aBusy, v.expBusy);
      check($sformatf("v%0d maskA", idx), aMask, v.expMask);
   endtask

   initial begin
      rst = 1'b1;
      we = '0; wa = '0; wd = '0; ra = '0; rv = 1'b0; rr = '0;
      cWe = '0; cWa = '0; cWd = '0; cRa = '0; cRv = 1'b0; cRr = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      ra = {5'd6, 5'd5};
      #1;
      check("reset rdA", aRd, 64'h0);
      check("reset maskA", aMask, 32'h0);
      check("reset maskC", cMask, 24'h0);

      //            we     wa0  wd0           wa1  wd1     ra0  ra1  rv  rr   expA0         expA1         expB0         busy   mask
      vecs.push_back('{2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0,  5'd5, 5'd6, 0, 5'd0, 32'hDEADBEEF, 32'h0,        32'h0,        2'b00, 32'h0});
      vecs.push_back('{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  5'd5, 5'd6, 0, 5'd0, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 2'b00, 32'h0});
      vecs.push_back('{2'b11, 5'd3, 32'h11,       5'd3, 32'h22, 5'd3, 5'd3, 0, 5'd0, 32'h22,       32'h22,       32'h0,        2'b00, 32'h0});
      vecs.push_back('{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  5'd3, 5'd0, 0, 5'd0, 32'h22,       32'h0,        32'h22,       2'b00, 32'h0});
      vecs.push_back('{2'b01, 5'd0, 32'h1234,     5'd0, 32'h0,  5'd0, 5'd0, 1, 5'd0, 32'h0,        32'h0,        32'h0,        2'b00, 32'h0});
      vecs.push_back('{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  5'd0, 5'd0, 0, 5'd0, 32'h0,        32'h0,        32'h0,        2'b00, 32'h0});
      vecs.push_back('{2'b01, 5'd7, 32'hAA,       5'd0, 32'h0,  5'd7, 5'd1, 0, 5'd0, 32'hAA,       32'h0,        32'h0,        2'b00, 32'h0});
      vecs.push_back('{2'b10, 5'd0, 32'h0,        5'd7, 32'hBB, 5'd7, 5'd7, 0, 5'd0, 32'hBB,       32'hBB,       32'hAA,       2'b00, 32'h0});
      vecs.push_back('{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  5'd7, 5'd7, 0, 5'd0, 32'hBB,       32'hBB,       32'hBB,       2'b00, 32'h0});
      vecs.push_back('{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  5'd9, 5'd9, 1, 5'd9, 32'h0,        32'h0,        32'h0,        2'b00, 32'h0});
      vecs.push_back('{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  5'd9, 5'd9, 0, 5'd0, 32'h0,        32'h0,        32'h0,        2'b11, 32'h200});
      vecs.push_back('{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  5'd9, 5'd9, 0, 5'd0, 32'h0,        32'h0,        32'h0,        2'b11, 32'h200});
      vecs.push_back('{2'b01, 5'd9, 32'h99,       5'd0, 32'h0,  5'd9, 5'd9, 0, 5'd0, 32'h99,       32'h99,       32'h0,        2'b11, 32'h200});
      vecs.push_back('{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  5'd9, 5'd9, 0, 5'd0, 32'h99,       32'h99,       32'h99,       2'b00, 32'h0});
      vecs.push_back('{2'b10, 5'd0, 32'h0,        5'd9, 32'h55, 5'd9, 5'd9, 1, 5'd9, 32'h55,       32'h55,       32'h99,       2'b00, 32'h0});
      vecs.push_back('{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  5'd9, 5'd9, 0, 5'd0, 32'h55,       32'h55,       32'h55,       2'b11, 32'h200});
      vecs.push_back('{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  5'd9, 5'd5, 1, 5'd9, 32'h55,       32'hDEADBEEF, 32'h55,       2'b01, 32'h200});
      vecs.push_back('{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  5'd9, 5'd5, 0, 5'd0, 32'h55,       32'hDEADBEEF, 32'h55,       2'b01, 32'h200});
      vecs.push_back('{2'b11, 5'd2, 32'h1,        5'd4, 32'h2,  5'd2, 5'd4, 0, 5'd0, 32'h1,        32'h2,        32'h0,        2'b00, 32'h200});
      vecs.push_back('{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  5'd2, 5'd4, 0, 5'd0, 32'h1,        32'h2,        32'h1,        2'b00, 32'h200});

      foreach (vecs[i]) applyVec(vecs[i], i);

      @(negedge clk);
      we = '0; rv = 1'b0;

      // Sweep: every legal address written once, three per cycle.
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         cWe = 3'b111;
         for (int k = 0; k < 3; k++) begin
            cWa[k*5 +: 5]  = 5'(3*j + k);
            cWd[k*16 +: 16] = sweepData(3*j + k);
         end
      end
      for (int j = 0; j < 6; j++) begin
         @(negedge clk);
         cWe = '0;
         for (int p = 0; p < 4; p++) cRa[p*5 +: 5] = 5'(4*j + p);
         #1;
         for (int p = 0; p < 4; p++)
            check($sformatf("sweep r%0d p%0d", 4*j + p, p), cRd[p*16 +: 16], sweepExp(4*j + p));
      end
      for (int j = 0; j < 6; j++) begin
         @(negedge clk);
         for (int p = 0; p < 4; p++) cRa[p*5 +: 5] = 5'(23 - (4*j + p));
         #1;
         for (int p = 0; p < 4; p++)
            check($sformatf("sweepRev r%0d p%0d", 23 - (4*j + p), p), cRd[p*16 +: 16], sweepExp(23 - (4*j + p)));
      end

      // Three-way write conflict: port 2 must win.
      @(negedge clk);
      cWe = 3'b111;
      cWa = {5'd5, 5'd5, 5'd5};
      cWd = {16'h3333, 16'h2222, 16'h1111};
      cRa = {5'd0, 5'd0, 5'd0, 5'd5};
      #1;
      check("conflict3 bypass", cRd[15:0], 16'h3333);
      @(negedge clk);
      cWe = '0;
      #1;
      check("conflict3 stored", cRd[15:0], 16'h3333);

      // Out-of-range write and reserve at address 30.
      @(negedge clk);
      cWe = 3'b100;
      cWa = {5'd30, 5'd0, 5'd0};
      cWd = {16'hFFFF, 16'h0, 16'h0};
      cRv = 1'b1;
      cRr = 5'd30;
      cRa = {5'd30, 5'd30, 5'd30, 5'd30};
      #1;
      check("oor bypass rd", cRd, 64'h0);
      check("oor busy", cBusy, 4'h0);
      @(negedge clk);
      cWe = '0;
      cRv = 1'b0;
      cRa = {5'd30, 5'd30, 5'd23, 5'd30};
      #1;
      check("oor stored rd0", cRd[15:0], 16'h0);
      check("oor r23 intact", cRd[31:16], sweepData(23));
      check("oor maskC", cMask, 24'h0);

      // Reserve on the sweep instance's last register.
      @(negedge clk);
      cRv = 1'b1;
      cRr = 5'd23;
      @(negedge clk);
      cRv = 1'b0;
      cRa = {5'd23, 5'd0, 5'd0, 5'd0};
      #1;
      check("sweep busy r23", cBusy, 4'b1000);
      check("sweep mask r23", cMask, 24'h800000);

      // Reset mid-operation: outputs are not gated, and the cycle's write and reserve are lost.
      @(negedge clk);
      rst = 1'b1;
      we  = 2'b01;
      wa  = {5'd0, 5'd6};
      wd  = {32'h0, 32'h66};
      rv  = 1'b1;
      rr  = 5'd10;
      ra  = {5'd6, 5'd5};
      #1;
      check("inreset rdA0", aRd[31:0], 32'hDEADBEEF);
      check("inreset rdA1 bypass", aRd[63:32], 32'h66);
      check("inreset rdB1", bRd[63:32], 32'h0);
      @(negedge clk);
      rst = 1'b0;
      we  = '0;
      rv  = 1'b0;
      #1;
      check("postreset rdA", aRd, 64'h0);
      check("postreset rdB", bRd, 64'h0);
      check("postreset maskA", aMask, 32'h0);
      check("postreset maskB", bMask, 32'h0);
      check("postreset maskC", cMask, 24'h0);

      $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/multiport_register_file.md
# multiport_register_file

Parametrised general-purpose register file for the datapath: configurable word width, depth, number of read ports and number of write ports. Adds synchronous clear, a hardwired zero register, optional same-cycle write-to-read bypass, deterministic multi-write priority, and a per-register busy scoreboard for pending writes. It sits in the decode stage, with the writeback stage driving its write ports and its reserve port.

## Interface
- WordLen, 32, bits per register
- WordCount, 32, number of registers; AW = $clog2(WordCount), minimum 1
- ReadPorts, 2, number of read ports (>=1)
- WritePorts, 2, number of write ports (>=1)
- ZeroReg, 1, 1: register 0 always reads 0, ignores writes, is never busy
- Bypass, 1, 1: a read sees same-cycle write data

- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- RegWrite  in  WritePorts  per-port write enable
- writeRegister  in  WritePorts*AW  packed write addresses; port k at [k*AW +: AW]
- WriteData  in  WritePorts*WordLen  packed write data
- readRegister  in  ReadPorts*AW  packed read addresses
- ReadData  out  ReadPorts*WordLen  packed read data
- readBusy  out  ReadPorts  1 when the addressed register has a pending write
- reserveValid  in  1  mark reserveRegister busy
- reserveRegister  in  AW  register to reserve
- busyMask  out  WordCount  current scoreboard, bit i = register i busy

## Operation
- Reset: on a clk edge with rst=1, all registers and busyMask clear to 0. Reset has priority over writes and reserves in the same cycle.
- Write: on a clk edge with rst=0, every port k with RegWrite[k]=1 writes WriteData[k] to writeRegister[k].
- Multiple ports to the same address in one cycle: the highest-index port wins, and the other ports' data for that address is discarded.
- ZeroReg=1: writes and reserves to address 0 are dropped. ReadData for address 0 is 0 and readBusy is 0. ZeroReg=0: register 0 is ordinary.
- Addresses >= WordCount (non-power-of-2 depth): writes and reserves are ignored, reads return 0, readBusy is 0.
- Read: combinational.
  - Bypass=1: if any enabled write port targets the read address this cycle (excluding dropped zero-register writes), ReadData is that port's WriteData, highest-index port winning. Otherwise ReadData is the stored value.
  - Bypass=0: ReadData is always the stored value.
- Scoreboard:
  - An enabled write to register i clears busyMask[i] at the edge.
  - reserveValid sets busyMask[reserveRegister] at the edge.
  - Simultaneous write and reserve to the same register: set wins, and the register stays busy. This models an older write retiring while a younger producer reserves.
  - Reserving a register that is already busy keeps it busy; there is no count.
- readBusy[p] = busyMask[readRegister p] after zero and out-of-range masking. readBusy is not affected by same-cycle writes, even with Bypass=1.

## Timing
- Write latency: data is stored at the next rising edge and visible on a non-bypassed read immediately after that edge.
- Bypass path: zero-cycle latency, purely combinational from WriteData and RegWrite to ReadData.
- Scoreboard: updates at the edge. busyMask and readBusy reflect the new state in the cycle after the edge.
- Reset values: all storage 0 and busyMask 0. Hence ReadData = 0 and readBusy = 0 for all addresses in the cycle after a reset edge, unless bypassed.
- Outputs are not gated by rst. While rst=1, reads show current storage, or bypass data when Bypass=1.
- Reset asserted mid-operation: pending reserves and writes in that cycle are lost, and all registers become 0.

## Test plan
- Reset clear: write 0xDEADBEEF to r5, then pulse rst for 1 cycle. Required: ReadData(r5) = 0 and busyMask = 0. A write to r6 in the reset cycle is lost, so r6 reads 0.
- Zero register (ZeroReg=1): write 0x1234 to r0 and reserve r0. Required: r0 reads 0, busyMask[0] = 0, readBusy = 0.
- Write conflict: in one cycle, port0 writes r3 = 0x11 and port1 writes r3 = 0x22. Required: r3 reads 0x22 after the edge.
- Bypass (Bypass=1): r7 holds 0xAA. In one cycle, port1 writes r7 = 0xBB while read port 0 addresses r7. Required: ReadData0 = 0xBB in the same cycle. With Bypass=0 the same stimulus gives 0xAA in that cycle and 0xBB in the next.
- Scoreboard: reserve r9 at cycle 0. Required: readBusy = 1 for r9 from cycle 1. Write r9 at cycle 3 with no reserve; required: busy clears in cycle 4. Write r9 and reserve r9 in the same cycle; required: busy stays 1.
- Parameter sweep: WordCount = 24, ReadPorts = 4, WritePorts = 3, WordLen = 16. Write all legal addresses from all ports, then read them on all ports. Required: correct data on every port. A write or reserve to address 30 is ignored and address 30 reads 0.
